// File: rtl/lsu_if.sv
// lsu_if: core-side request/response and data-memory port bundle of the load/store unit.
// Revision: 1.0
`default_nettype none

interface lsu_if #(
  parameter int DATA_BITS = 32
);
  logic                 mem_read;
  logic                 mem_write;
  logic [2:0]           funct3;
  logic [DATA_BITS-1:0] address;
  logic [DATA_BITS-1:0] store_data;
  logic [DATA_BITS-1:0] load_data;
  logic                 load_valid;
  logic                 stall;
  logic                 fault;
  logic [DATA_BITS-3:0] dm_address;
  logic [DATA_BITS-1:0] dm_wdata;
  logic                 dm_we;
  logic                 dm_re;
  logic [DATA_BITS-1:0] dm_rdata;

  // Driver side: the execute stage together with the data memory.
  modport master (
    output mem_read, mem_write, funct3, address, store_data, dm_rdata,
    input  load_data, load_valid, stall, fault, dm_address, dm_wdata, dm_we, dm_re
  );

  modport slave (
    input  mem_read, mem_write, funct3, address, store_data, dm_rdata,
    output load_data, load_valid, stall, fault, dm_address, dm_wdata, dm_we, dm_re
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit: RV32I sub-word load/store engine over a word-addressed RAM.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses via sticky fault.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int DATA_BITS = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  lsu_if.slave      bus
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_DATA = 2'd1,
    S_RMW_MERGE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_funct3;
  logic [1:0]           r_lane;
  logic [15:0]          r_store;
  logic [DATA_BITS-1:0] r_load_data;
  logic                 r_load_valid;
  logic                 r_fault;

  logic                 w_req;
  logic                 w_word;
  logic                 w_misalign;
  logic                 w_accept;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [DATA_BITS-1:0] w_load_ext;
  logic [DATA_BITS-1:0] w_merged;

  assign w_req  = bus.mem_read | bus.mem_write;
  // Anything other than B/BU/H/HU (including 011/110/111) is a word access.
  assign w_word = bus.funct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (~bus.funct3[1] & bus.funct3[0] & bus.address[0]) |
                      (w_word & (bus.address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = w_req & ~w_misalign;

  assign w_byte = bus.dm_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = bus.dm_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_ext = bus.dm_rdata;
    w_merged   = bus.dm_rdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_load_ext = {{(DATA_BITS-8){w_byte[7] & ~r_funct3[2]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_store[7:0];
      end
      2'b01: begin
        w_load_ext = {{(DATA_BITS-16){w_half[15] & ~r_funct3[2]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_store;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.dm_we    = 1'b0;
    bus.dm_re    = 1'b0;
    bus.stall    = 1'b0;
    bus.dm_wdata = bus.store_data;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.mem_write && w_word) begin
              bus.dm_we = 1'b1;
            end else begin
              bus.dm_re = 1'b1;
              bus.stall = 1'b1;
            end
          end
        end
        S_LOAD_DATA: bus.stall = 1'b1;
        S_RMW_MERGE: begin
          bus.dm_we    = 1'b1;
          bus.dm_wdata = w_merged;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_store      <= 16'h0000;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_misalign) begin
            r_fault <= 1'b1;
          end
          // Lane/size are captured so the second cycle does not depend on the core.
          if (w_accept) begin
            r_funct3 <= bus.funct3;
            r_lane   <= bus.address[1:0];
            r_store  <= bus.store_data[15:0];
            if (!bus.mem_write) begin
              r_state <= S_LOAD_DATA;
            end else if (!w_word) begin
              r_state <= S_RMW_MERGE;
            end
          end
        end
        S_LOAD_DATA: begin
          r_load_data  <= w_load_ext;
          r_load_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        S_RMW_MERGE: r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dm_address = bus.address[DATA_BITS-1:2];
  assign bus.load_data  = r_load_data;
  assign bus.load_valid = r_load_valid;
  assign bus.fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random loads/stores against a byte-array memory model.
// Revision: 1.0
`default_nettype none

module tb_load_store_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lsu_if #(.DATA_BITS(32)) bus ();

  load_store_unit #(.DATA_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical word memory seen by the DUT (64 bytes).
  logic [31:0] mem [0:15];
  logic [31:0] r_rdata;
  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_address[3:0]] <= bus.dm_wdata;
    if (bus.dm_re) r_rdata <= mem[bus.dm_address[3:0]];
  end
  assign bus.dm_rdata = r_rdata;

  // Reference model: little-endian byte array.
  logic [7:0] ref_b [0:63];

  function automatic logic [31:0] ref_word(input int base);
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'b000;
    bus.address    = 32'h0;
    bus.store_data = 32'h0;
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] ld);
    int sz;
    int base;
    logic [31:0] exp_v;
    bit mis;
    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    base = int'(addr[5:0]) - (int'(addr[5:0]) % sz);
    mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis  = (int'(addr[5:0]) % sz) != 0;
`endif
    ld = 32'h0;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
    bus.address    = addr;
    bus.store_data = data;
    @(negedge clk);
    chk("lv_low_T", {31'b0, bus.load_valid}, 32'h0);
    chk("dm_addr", {2'b0, bus.dm_address}, addr >> 2);
    if (mis) begin
      chk("mis_re", {31'b0, bus.dm_re}, 32'h0);
      chk("mis_we", {31'b0, bus.dm_we}, 32'h0);
      chk("mis_stall", {31'b0, bus.stall}, 32'h0);
      @(posedge clk); #1;
      idle_inputs();
      chk("mis_fault", {31'b0, bus.fault}, 32'h1);
    end else if (wr && sz == 4) begin
      chk("sw_we", {31'b0, bus.dm_we}, 32'h1);
      chk("sw_re", {31'b0, bus.dm_re}, 32'h0);
      chk("sw_stall", {31'b0, bus.stall}, 32'h0);
      chk("sw_wdata", bus.dm_wdata, data);
      for (int i = 0; i < 4; i++) ref_b[base+i] = data[8*i +: 8];
      @(posedge clk); #1;
      idle_inputs();
      chk("sw_mem", mem[base/4], ref_word(base));
    end else if (wr) begin
      chk("rmw_re", {31'b0, bus.dm_re}, 32'h1);
      chk("rmw_we0", {31'b0, bus.dm_we}, 32'h0);
      chk("rmw_stall", {31'b0, bus.stall}, 32'h1);
      for (int i = 0; i < sz; i++) ref_b[base+i] = data[8*i +: 8];
      exp_v = ref_word(base - (base % 4));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rmw_we1", {31'b0, bus.dm_we}, 32'h1);
      chk("rmw_stall1", {31'b0, bus.stall}, 32'h0);
      chk("rmw_wdata", bus.dm_wdata, exp_v);
      @(posedge clk); #1;
      idle_inputs();
      chk("rmw_mem", mem[base/4], exp_v);
    end else begin
      if (sz == 1)      exp_v = f3[2] ? {24'h0, ref_b[base]} : {{24{ref_b[base][7]}}, ref_b[base]};
      else if (sz == 2) exp_v = f3[2] ? {16'h0, ref_b[base+1], ref_b[base]}
                                      : {{16{ref_b[base+1][7]}}, ref_b[base+1], ref_b[base]};
      else              exp_v = ref_word(base);
      chk("ld_re", {31'b0, bus.dm_re}, 32'h1);
      chk("ld_stall", {31'b0, bus.stall}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ld_stall1", {31'b0, bus.stall}, 32'h1);
      chk("ld_we1", {30'b0, bus.dm_we, bus.dm_re}, 32'h0);
      chk("ld_lv1", {31'b0, bus.load_valid}, 32'h0);
      @(posedge clk); #1;
      idle_inputs();
      chk("ld_lv2", {31'b0, bus.load_valid}, 32'h1);
      chk("ld_data", bus.load_data, exp_v);
      ld = bus.load_data;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          wr;
    n_checks = 0;
    n_fail   = 0;
    r_rdata  = 32'h0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = mem[i][8*j +: 8];
    end
    idle_inputs();
    bus.mem_read = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {29'b0, bus.stall, bus.dm_re, bus.dm_we}, 32'h0);
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ld", bus.load_data, 32'h0);
    chk("rst_lv_fault", {30'b0, bus.load_valid, bus.fault}, 32'h0);

    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, ld);
    do_op(0, 1, 3'b010, 32'h10, 32'h11223344, ld);
    do_op(0, 1, 3'b000, 32'h12, 32'h000000AB, ld);
    chk("sb_0x12", mem[4], 32'h11AB3344);

    do_op(0, 1, 3'b010, 32'h0, 32'h8000FF80, ld);
    do_op(1, 0, 3'b000, 32'h0, 32'h0, ld); chk("lb", ld, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h0, 32'h0, ld); chk("lbu", ld, 32'h00000080);
    do_op(1, 0, 3'b001, 32'h2, 32'h0, ld); chk("lh", ld, 32'hFFFF8000);
    do_op(1, 0, 3'b101, 32'h2, 32'h0, ld); chk("lhu", ld, 32'h00008000);

    do_op(0, 1, 3'b010, 32'h4, 32'h11223344, ld);
    do_op(0, 1, 3'b001, 32'h6, 32'h00001234, ld);
    do_op(1, 0, 3'b010, 32'h4, 32'h0, ld); chk("sh_then_lw", ld, 32'h12343344);

    // Reset while the load is in its data cycle.
    bus.mem_read = 1'b1;
    bus.funct3   = 3'b010;
    bus.address  = 32'h4;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {29'b0, bus.stall, bus.dm_re, bus.dm_we}, 32'h0);
    chk("rst_mid_ld", bus.load_data, 32'h0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_lv", {30'b0, bus.load_valid, bus.fault}, 32'h0);
    end
    @(posedge clk); #1;

    do_op(1, 0, 3'b010, 32'h5, 32'h0, ld);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    chk("fault_held", {31'b0, bus.fault}, 32'h1);
`else
    chk("lw_mis", ld, mem[1]);
    chk("fault_off", {31'b0, bus.fault}, 32'h0);
`endif

    for (int n = 0; n < 60; n++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
`ifdef LSU_MISALIGN_TRAP_EN
      addr = (f3[1:0] == 2'b00) ? addr : (f3[1:0] == 2'b01) ? (addr & ~32'h1) : (addr & ~32'h3);
`endif
      wr = $urandom_range(0, 1) == 1;
      do_op($urandom_range(0, 1) == 1 || !wr, wr, f3, addr, $urandom, ld);
    end
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_word(4*i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store engine between the execute stage (ALU result, register-bank read port 2, main-controller memory_read/memory_write) and the word-addressed data memory. Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses: sign/zero-extends loads and performs read-modify-write for byte/halfword stores. Asserts stall to the core while a multi-cycle access is in flight.

## Interface
- data_bits, 32, data and byte-address width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  load request (main controller)
- mem_write  in  1  store request (main controller)
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  in  data_bits  byte address (ALU result)
- store_data  in  data_bits  store operand (register read_data_2)
- load_data  out  data_bits  extended load result, registered
- load_valid  out  1  one-cycle pulse, load_data valid
- stall  out  1  hold PC/pipeline; request inputs must stay stable while high
- fault  out  1  sticky misalignment flag (see Configuration)
- dm_address  out  data_bits-2  word address = address[data_bits-1:2]
- dm_wdata  out  data_bits  word written to data memory
- dm_we  out  1  data memory write enable
- dm_re  out  1  data memory read enable
- dm_rdata  in  data_bits  data memory read word, valid the cycle after dm_re

## Operation
- States: IDLE, LOAD_DATA, RMW_MERGE.
- Request accepted only in IDLE; inputs ignored in other states. mem_read and mem_write both high: treated as store.
- Lanes: byte k = address[1:0], bits [8k+7:8k]; halfword lane = address[1], bits [16h+15:16h].
- SW (IDLE): dm_we=1, dm_wdata=store_data, stall=0, stay IDLE. Single cycle.
- SB/SH (IDLE): dm_re=1, stall=1, go RMW_MERGE. RMW_MERGE: dm_wdata = dm_rdata with addressed lane replaced by store_data[7:0]/[15:0], dm_we=1, stall=0, go IDLE.
- Loads (IDLE): dm_re=1, stall=1, go LOAD_DATA. LOAD_DATA: stall=1, extract lane from dm_rdata, sign-extend (B/H) or zero-extend (BU/HU, W unchanged), register into load_data, set load_valid for next cycle, go IDLE.
- Unsupported funct3 (011, 110, 111): executed as word access.
- dm_address combinational from address in every state (address held stable by stall).
- dm_we, dm_re, stall combinational from state and request; all forced 0 while rst high.

## Timing
- Reset values: state IDLE, load_data 0, load_valid 0, fault 0; dm_we/dm_re/stall 0.
- SW: latency 1 cycle, write in request cycle T.
- SB/SH: read at T, write at T+1; stall high in T only.
- Loads: read at T, capture at T+1, load_valid=1 and load_data valid at T+2; stall high T and T+1; load_data holds until next load.
- load_valid high exactly one cycle per load.
- Reset mid-operation (any state): immediate return to IDLE, no pending write issued, no load_valid pulse, fault cleared.
- Back-to-back: new request accepted in the cycle after returning to IDLE (T+1 for SW, T+2 for sub-word store/load).

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned access (H/HU/SH with address[0]=1; W/SW with address[1:0]≠0) in IDLE performs no memory access (dm_we=dm_re=0, stall=0, no load_valid) and sets fault the next cycle; fault stays 1 until rst.
- Not defined: fault tied 0; halfword access uses address[1] only, word access ignores address[1:0]; access proceeds normally.

## Test plan
- Reset mid-load: assert rst during LOAD_DATA -> state IDLE, load_valid never pulses, all outputs 0.
- SW addr 0x10, data 0xDEADBEEF -> dm_address 0x4, dm_we=1, dm_wdata 0xDEADBEEF same cycle, stall 0.
- Word at 0x4 = 0x11223344; SB addr 0x12, data 0xAB -> read cycle then write 0x11AB3344, stall high 1 cycle.
- Word 0x8000FF80 at 0x0: LB addr 0x0 -> 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x2 -> 0xFFFF8000; LHU -> 0x00008000; each load_valid at T+2.
- SH addr 0x6, data 0x1234 over 0x11223344 -> writes 0x12343344; immediately followed LW addr 0x4 -> load_data 0x12343344.
- LSU_MISALIGN_TRAP_EN: LW addr 0x5 -> no dm_re, fault=1 next cycle and held; without macro -> reads word 0x1, fault 0.
